// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-side pointer controller for a dual-clock FIFO, plus its Gray code helpers.
// Optional sticky protocol checker (err output) is enabled by defining FIFO_WR_PTR_CHECK_EN.

module int_to_gray #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);
    assign gray = bin ^ (bin >> 1);
endmodule

module gray_to_int #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);
    // Each binary bit is the XOR of all Gray bits at and above its position.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end
endmodule

module fifo_wr_ptr_ctrl #(
    parameter int ADDR_BITS         = 4,
    parameter int SYNC_STAGES       = 2,
    parameter int ALMOST_FULL_LEVEL = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    output logic                 wr_en,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [ADDR_BITS:0]   wr_ptr_gray,
    input  logic [ADDR_BITS:0]   rd_ptr_gray_async,
    output logic [ADDR_BITS:0]   fill_level,
    output logic                 full,
    output logic                 almost_full
`ifdef FIFO_WR_PTR_CHECK_EN
    ,
    output logic                 err
`endif
);
    localparam int PTR_BITS = ADDR_BITS + 1;
    localparam int DEPTH    = 2 ** ADDR_BITS;

    logic [PTR_BITS-1:0] wr_ptr_bin;
    logic [PTR_BITS-1:0] wr_ptr_bin_nxt;
    logic [PTR_BITS-1:0] wr_ptr_gray_nxt;
    logic [PTR_BITS-1:0] rd_ptr_bin;
    logic [PTR_BITS-1:0] rd_sync [SYNC_STAGES];
    logic                accept;

    // wr_ready depends only on registered pointers, never on wr_valid.
    assign wr_ready = !full;
    assign accept   = wr_valid && wr_ready;
    assign wr_en    = accept && reset_n;
    assign wr_addr  = wr_ptr_bin[ADDR_BITS-1:0];

    always_comb begin
        // NOTE: assign a default before any condition so no path leaves the signal unassigned (no latch).
        wr_ptr_bin_nxt = wr_ptr_bin;
        if (accept) begin
            wr_ptr_bin_nxt = wr_ptr_bin + PTR_BITS'(1);
        end
    end

    int_to_gray #(.WIDTH(PTR_BITS)) u_wr_i2g (
        .bin  (wr_ptr_bin_nxt),
        .gray (wr_ptr_gray_nxt)
    );

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_bin  <= '0;
            wr_ptr_gray <= '0;
        end else begin
            wr_ptr_bin  <= wr_ptr_bin_nxt;
            wr_ptr_gray <= wr_ptr_gray_nxt;
        end
    end

    // NOTE: the synchroniser stages are reset too; stale read pointers would corrupt fill_level after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rd_sync[i] <= '0;
            end
        end else begin
            rd_sync[0] <= rd_ptr_gray_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rd_sync[i] <= rd_sync[i-1];
            end
        end
    end

    gray_to_int #(.WIDTH(PTR_BITS)) u_rd_g2i (
        .gray (rd_sync[SYNC_STAGES-1]),
        .bin  (rd_ptr_bin)
    );

    // The extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign fill_level  = wr_ptr_bin - rd_ptr_bin;
    assign full        = (fill_level == PTR_BITS'(DEPTH));
    assign almost_full = (fill_level >= PTR_BITS'(ALMOST_FULL_LEVEL));

`ifdef FIFO_WR_PTR_CHECK_EN
    logic [PTR_BITS-1:0] sync_delta;
    logic                multi_bit_step;
    logic                fill_overrun;

    // The second-to-last stage is the next value of the last stage, so the step is seen one cycle early.
    assign sync_delta     = rd_sync[SYNC_STAGES-1] ^ rd_sync[SYNC_STAGES-2];
    assign multi_bit_step = (sync_delta & (sync_delta - PTR_BITS'(1))) != '0;
    assign fill_overrun   = fill_level > PTR_BITS'(DEPTH);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else if (multi_bit_step || fill_overrun) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Directed, table-driven bench for fifo_wr_ptr_ctrl (default parameters).
// Exercises the err checker too when FIFO_WR_PTR_CHECK_EN is defined.

module tb_fifo_wr_ptr_ctrl;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [4:0] wr_ptr_gray;
    logic [4:0] rd_ptr_gray_async;
    logic [4:0] fill_level;
    logic       full;
    logic       almost_full;
`ifdef FIFO_WR_PTR_CHECK_EN
    logic       err;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    fifo_wr_ptr_ctrl dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_en             (wr_en),
        .wr_addr           (wr_addr),
        .wr_ptr_gray       (wr_ptr_gray),
        .rd_ptr_gray_async (rd_ptr_gray_async),
        .fill_level        (fill_level),
        .full              (full),
        .almost_full       (almost_full)
`ifdef FIFO_WR_PTR_CHECK_EN
        ,
        .err               (err)
`endif
    );

    typedef struct {
        logic       valid;
        logic [4:0] rd;
        logic       en;
        logic [3:0] addr;
        logic [4:0] gray;
        logic [4:0] fill;
        logic       full;
        logic       af;
    } vec_t;

    vec_t vecs[25];

    function automatic logic [4:0] bin2gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [4:0] gray2bin(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] wp;
    logic [4:0] q0, q1;
    logic [4:0] rd_drv;
    logic [4:0] prev_gray;
    int         cnt;

    initial begin
        // Fill: 20 cycles of wr_valid with the reader parked at 0.
        for (int i = 0; i < 20; i++) begin
            int p;
            p = (i < 16) ? i : 16;
            vecs[i].valid = 1'b1;
            vecs[i].rd    = 5'd0;
            vecs[i].en    = (i < 16);
            vecs[i].addr  = 4'(p);
            vecs[i].gray  = bin2gray(5'(p));
            vecs[i].fill  = 5'(p);
            vecs[i].full  = (p == 16);
            vecs[i].af    = (p >= 12);
        end
        // Drain visibility: read pointer 4 then 5 (Gray 00110, 00111) through two sync stages.
        vecs[20] = '{1'b0, 5'b00110, 1'b0, 4'd0, 5'b11000, 5'd16, 1'b1, 1'b1};
        vecs[21] = '{1'b0, 5'b00110, 1'b0, 4'd0, 5'b11000, 5'd16, 1'b1, 1'b1};
        vecs[22] = '{1'b0, 5'b00111, 1'b0, 4'd0, 5'b11000, 5'd12, 1'b0, 1'b1};
        vecs[23] = '{1'b0, 5'b00111, 1'b0, 4'd0, 5'b11000, 5'd12, 1'b0, 1'b1};
        vecs[24] = '{1'b0, 5'b00111, 1'b0, 4'd0, 5'b11000, 5'd11, 1'b0, 1'b0};

        // Reset held with wr_valid high.
        reset_n           = 1'b0;
        wr_valid          = 1'b1;
        rd_ptr_gray_async = 5'd0;
        step();
        step();
        check("reset_wr_en", wr_en, 1'b0);
        check("reset_gray", wr_ptr_gray, 5'd0);
        check("reset_fill", fill_level, 5'd0);
        check("reset_full", full, 1'b0);
        check("reset_af", almost_full, 1'b0);
        check("reset_ready", wr_ready, 1'b1);
        reset_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            wr_valid          = vecs[i].valid;
            rd_ptr_gray_async = vecs[i].rd;
            @(negedge clk);
            check($sformatf("v%0d_wr_en", i), wr_en, vecs[i].en);
            check($sformatf("v%0d_addr", i), wr_addr, vecs[i].addr);
            check($sformatf("v%0d_gray", i), wr_ptr_gray, vecs[i].gray);
            check($sformatf("v%0d_fill", i), fill_level, vecs[i].fill);
            check($sformatf("v%0d_full", i), full, vecs[i].full);
            check($sformatf("v%0d_af", i), almost_full, vecs[i].af);
            check($sformatf("v%0d_ready", i), wr_ready, !vecs[i].full);
            step();
        end

        // Mid-operation reset at fill 9 (read pointer 7 = Gray 00100).
        wr_valid          = 1'b0;
        rd_ptr_gray_async = 5'b00100;
        step();
        step();
        @(negedge clk);
        check("pre_reset_fill", fill_level, 5'd9);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_fill", fill_level, 5'd0);
        check("midrst_gray", wr_ptr_gray, 5'd0);
        check("midrst_addr", wr_addr, 4'd0);
        check("midrst_ready", wr_ready, 1'b1);
        @(posedge clk);
        #1;
        rd_ptr_gray_async = 5'd0;
        step();
        step();
        check("midrst_settled_fill", fill_level, 5'd0);

        // Wrap: 70 accepts with the reader trailing 3 behind.
        wp        = 5'd0;
        q0        = 5'd0;
        q1        = 5'd0;
        cnt       = 0;
        prev_gray = wr_ptr_gray;
        wr_valid  = 1'b1;
        for (int n = 0; n < 70; n++) begin
            rd_drv            = (cnt >= 3) ? bin2gray(5'(cnt - 3)) : 5'd0;
            rd_ptr_gray_async = rd_drv;
            @(negedge clk);
            check($sformatf("wrap%0d_wr_en", n), wr_en, 1'b1);
            check($sformatf("wrap%0d_addr", n), wr_addr, wp[3:0]);
            check($sformatf("wrap%0d_fill", n), fill_level, 5'(wp - gray2bin(q1)));
            @(posedge clk);
            q1 = q0;
            q0 = rd_drv;
            wp = wp + 5'd1;
            cnt++;
            #1;
            check($sformatf("wrap%0d_gray", n), wr_ptr_gray, bin2gray(wp));
            check($sformatf("wrap%0d_onebit", n), $countones(wr_ptr_gray ^ prev_gray), 1);
            if (wp == 5'd0) begin
                check("wrap_31_to_0_prev", prev_gray, 5'b10000);
                check("wrap_31_to_0_cur", wr_ptr_gray, 5'b00000);
            end
            prev_gray = wr_ptr_gray;
        end
        wr_valid = 1'b0;

`ifdef FIFO_WR_PTR_CHECK_EN
        reset_n           = 1'b0;
        rd_ptr_gray_async = 5'd0;
        step();
        reset_n = 1'b1;
        step();
        check("err_after_reset", err, 1'b0);
        rd_ptr_gray_async = 5'b00011;
        step();
        check("err_after_1_edge", err, 1'b0);
        step();
        check("err_after_2_edges", err, 1'b1);
        wr_valid = 1'b1;
        for (int k = 0; k < 4; k++) step();
        wr_valid = 1'b0;
        check("err_sticky", err, 1'b1);
        reset_n = 1'b0;
        step();
        reset_n           = 1'b1;
        rd_ptr_gray_async = 5'd0;
        check("err_cleared", err, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
